// File: rtl/baud_controller_param.sv
// Baud-rate tick generator: oversampled, 1x and mid-bit strobes from one system clock.
// Define BAUD_FRAC_EN to replace the integer divider with a fractional phase accumulator.
module baud_controller_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int ACC_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] baud_select,
  input  logic       sync,
  output logic       sample_ENABLE,
  output logic       tx_ENABLE,
  output logic       mid_ENABLE
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);

  function automatic int unsigned baud_of(input int unsigned sel);
    case (sel)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  logic [2:0]        sel_q;
  logic              primed;
  logic              clear;
  logic              tick;
  logic [SAMP_W-1:0] samp_cnt;

  // Counters are already zero out of reset, so the first copy load is not a rate change.
  assign clear = sync | (primed & (baud_select != sel_q));

`ifdef BAUD_FRAC_EN
  function automatic logic [ACC_W-1:0] inc_of(input int unsigned sel);
    return ACC_W'(baud_of(sel) * OVERSAMPLE);
  endfunction

  localparam logic [ACC_W-1:0] INC_TAB [8] = '{inc_of(0), inc_of(1), inc_of(2), inc_of(3),
                                               inc_of(4), inc_of(5), inc_of(6), inc_of(7)};
  localparam logic [ACC_W-1:0] FREQ = ACC_W'(CLK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc + INC_TAB[sel_q];
  assign tick    = en & ~clear & (acc_sum >= FREQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= tick ? acc_sum - FREQ : acc_sum;
  end
`else
  // Table holds DIV-1 so the wrap compare needs no subtractor.
  function automatic logic [DIV_W-1:0] div_max_of(input int unsigned sel);
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] num;
    step = ACC_W'(baud_of(sel) * OVERSAMPLE);
    num  = ACC_W'(CLK_FREQ) + (step >> 1);
    return DIV_W'(num / step - 1);
  endfunction

  localparam logic [DIV_W-1:0] DIV_MAX [8] = '{div_max_of(0), div_max_of(1), div_max_of(2),
                                               div_max_of(3), div_max_of(4), div_max_of(5),
                                               div_max_of(6), div_max_of(7)};

  logic [DIV_W-1:0] div_cnt;

  assign tick = en & ~clear & (div_cnt == DIV_MAX[sel_q]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      div_cnt <= '0;
    else if (clear) div_cnt <= '0;
    else if (en)    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q         <= '0;
      primed        <= 1'b0;
      samp_cnt      <= '0;
      sample_ENABLE <= 1'b0;
      tx_ENABLE     <= 1'b0;
      mid_ENABLE    <= 1'b0;
    end else begin
      sel_q         <= baud_select;
      primed        <= 1'b1;
      sample_ENABLE <= tick;
      tx_ENABLE     <= tick && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
      mid_ENABLE    <= tick && (samp_cnt == SAMP_W'(OVERSAMPLE / 2 - 1));
      if (clear)     samp_cnt <= '0;
      else if (tick) samp_cnt <= samp_cnt + SAMP_W'(1);
    end
  end

endmodule

// File: tb/tb_baud_controller_param.sv
// Self-checking bench for baud_controller_param: vector table, directed corner cases
// and randomized stimulus against an arithmetic reference model.
module tb_baud_controller_param;

  localparam int CLK_FREQ = 50_000_000;
  localparam int OS       = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic       sample_ENABLE, tx_ENABLE, mid_ENABLE;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled cycles and ticks counted since the last clear.
  longint     k_m, t_m;
  logic [2:0] prev_sel;
  bit         have_prev;
  logic [2:0] exp_out;

  baud_controller_param #(
    .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .DIV_W(16), .ACC_W(32)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .baud_select(baud_select), .sync(sync),
    .sample_ENABLE(sample_ENABLE), .tx_ENABLE(tx_ENABLE), .mid_ENABLE(mid_ENABLE)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic longint baud_of(input logic [2:0] s);
    case (s)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // A tick lands on the k-th enabled cycle after a clear.
  function automatic bit model_tick(input longint k, input logic [2:0] s);
    longint step;
`ifndef BAUD_FRAC_EN
    longint d;
`endif
    step = baud_of(s) * OS;
`ifdef BAUD_FRAC_EN
    return ((k * step) / CLK_FREQ) != (((k - 1) * step) / CLK_FREQ);
`else
    d = (2 * longint'(CLK_FREQ) + step) / (2 * step);
    return (k % d) == 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    k_m = 0; t_m = 0; have_prev = 1'b0; exp_out = '0;
  endtask

  task automatic model_step(input logic e, input logic [2:0] s, input logic sy);
    bit change;
    change    = have_prev && (s != prev_sel);
    prev_sel  = s;
    have_prev = 1'b1;
    exp_out   = '0;
    if (sy || change) begin
      k_m = 0; t_m = 0;
    end else if (e) begin
      k_m++;
      if (model_tick(k_m, s)) begin
        t_m++;
        exp_out[2] = 1'b1;
        exp_out[1] = (t_m % OS) == 0;
        exp_out[0] = (t_m % OS) == OS / 2;
      end
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [2:0] s, input logic sy);
    en = e; baud_select = s; sync = sy;
    @(posedge clk);
    #1;
    model_step(e, s, sy);
    checkOutput("outputs_vs_model", longint'({sample_ENABLE, tx_ENABLE, mid_ENABLE}),
                longint'(exp_out));
  endtask

  task automatic do_reset(input logic [2:0] s);
    reset = 1'b1; en = 1'b1; sync = 1'b0; baud_select = s;
    #150;
    checkOutput("reset_outputs_zero", longint'({sample_ENABLE, tx_ENABLE, mid_ENABLE}), 0);
    model_reset();
    reset = 1'b0;
  endtask

  // Runs enabled cycles until the chosen strobe (2=sample,1=tx,0=mid) fires or max expires.
  task automatic run_measure(input logic [2:0] s, input int max, input int stop_bit,
                             output int f_s, output int f_t, output int f_m);
    logic [2:0] v;
    f_s = 0; f_t = 0; f_m = 0;
    for (int i = 1; i <= max; i++) begin
      applyStimulus(1'b1, s, 1'b0);
      v = {sample_ENABLE, tx_ENABLE, mid_ENABLE};
      if (v[2] && f_s == 0) f_s = i;
      if (v[1] && f_t == 0) f_t = i;
      if (v[0] && f_m == 0) f_m = i;
      if (v[stop_bit]) break;
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic       en;
    int         cycles;
    int         n_s;
    int         n_t;
    int         n_m;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int fs, ft, fm, ns, nt, nm, pulses;
    logic [2:0] cur_sel;
    logic       e, sy;

    tbl[0] = '{3'b111, 1'b1,   432, 16, 1, 1};
    tbl[1] = '{3'b111, 1'b1, 15625, 578, 36, 36};
    tbl[2] = '{3'b000, 1'b1, 20834, 2, 0, 0};
    tbl[3] = '{3'b011, 1'b1,  5216, 16, 1, 1};
    tbl[4] = '{3'b111, 1'b0,  1000, 0, 0, 0};
    tbl[5] = '{3'b100, 1'b1,  1630, 10, 0, 1};
`ifdef BAUD_FRAC_EN
    tbl[0] = '{3'b111, 1'b1,   432, 15, 0, 1};
    tbl[1] = '{3'b111, 1'b1, 15625, 576, 36, 36};
`endif

    model_reset();
    for (int i = 0; i < 6; i++) begin
      do_reset(tbl[i].sel);
      ns = 0; nt = 0; nm = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        applyStimulus(tbl[i].en, tbl[i].sel, 1'b0);
        ns += int'(sample_ENABLE);
        nt += int'(tx_ENABLE);
        nm += int'(mid_ENABLE);
      end
      checkOutput($sformatf("vec%0d_sample_count", i), ns, tbl[i].n_s);
      checkOutput($sformatf("vec%0d_tx_count", i), nt, tbl[i].n_t);
      checkOutput($sformatf("vec%0d_mid_count", i), nm, tbl[i].n_m);
    end

    // First strobes after reset release, then steady sample spacing.
    do_reset(3'b111);
    run_measure(3'b111, 600, 1, fs, ft, fm);
`ifdef BAUD_FRAC_EN
    checkOutput("first_sample", fs, 28);
    checkOutput("first_mid", fm, 218);
    checkOutput("first_tx", ft, 435);
`else
    checkOutput("first_sample", fs, 27);
    checkOutput("first_mid", fm, 216);
    checkOutput("first_tx", ft, 432);
`endif
    run_measure(3'b111, 100, 2, fs, ft, fm);
    checkOutput("sample_gap", fs, 27);

    // Rate change mid-period.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'b111, 1'b0);
    applyStimulus(1'b1, 3'b011, 1'b0);
    checkOutput("no_pulse_on_rate_change", longint'(sample_ENABLE), 0);
    run_measure(3'b011, 400, 2, fs, ft, fm);
    checkOutput("rate_change_latency", fs, 326);
    run_measure(3'b011, 400, 2, fs, ft, fm);
    checkOutput("new_rate_period", fs, 326);

    // sync 10 cycles after a tick.
    applyStimulus(1'b1, 3'b111, 1'b0);
    run_measure(3'b111, 100, 2, fs, ft, fm);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 3'b111, 1'b0);
    applyStimulus(1'b1, 3'b111, 1'b1);
    checkOutput("no_pulse_on_sync", longint'(sample_ENABLE), 0);
    run_measure(3'b111, 300, 0, fs, ft, fm);
`ifdef BAUD_FRAC_EN
    checkOutput("sync_first_sample", fs, 28);
    checkOutput("sync_first_mid", fm, 218);
`else
    checkOutput("sync_first_sample", fs, 27);
    checkOutput("sync_first_mid", fm, 216);
`endif

    // en dropped at divide count 13.
    run_measure(3'b111, 100, 2, fs, ft, fm);
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 3'b111, 1'b0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 3'b111, 1'b0);
      pulses += int'(sample_ENABLE) + int'(tx_ENABLE) + int'(mid_ENABLE);
    end
    checkOutput("no_pulses_while_disabled", pulses, 0);
    run_measure(3'b111, 100, 2, fs, ft, fm);
`ifndef BAUD_FRAC_EN
    checkOutput("resume_latency", fs, 14);
`endif

    // Reset asserted right after the 9th tick of a bit.
    do_reset(3'b111);
    for (int i = 0; i < 9; i++) run_measure(3'b111, 100, 2, fs, ft, fm);
    checkOutput("ninth_tick_present", longint'(sample_ENABLE), 1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_clear", longint'({sample_ENABLE, tx_ENABLE, mid_ENABLE}), 0);
    #148;
    model_reset();
    reset = 1'b0;
    run_measure(3'b111, 600, 1, fs, ft, fm);
`ifdef BAUD_FRAC_EN
    checkOutput("tx_after_reset", ft, 435);
`else
    checkOutput("tx_after_reset", ft, 432);
`endif

    // Randomized enable, sync and rate changes among the faster rates.
    cur_sel = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) cur_sel = 3'(5 + $urandom_range(0, 2));
      e  = ($urandom_range(0, 9) != 0);
      sy = ($urandom_range(0, 199) == 0);
      applyStimulus(e, cur_sel, sy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_controller_param.md
# baud_controller_param

Parametrised baud-rate tick generator for the UART datapath, replacing the fixed 8-rate baud controller. It produces an oversampled receiver strobe (sample_ENABLE), a 1x transmitter strobe (tx_ENABLE) and a mid-bit strobe (mid_ENABLE) from a single system clock. It also adds enable gating, phase resynchronisation on receiver start-bit detection and safe rate switching. It sits between the clock/reset root and the UART TX/RX FSMs.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- OVERSAMPLE, 16, sample ticks per bit; power of two, >= 4
- DIV_W, 16, width of the integer divide counter
- ACC_W, 32, width of the fractional phase accumulator; must hold CLK_FREQ + max increment
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  run enable; low freezes all counters
- baud_select  input  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud
- sync  input  1  one-cycle pulse from RX on start-bit edge; realigns phase
- sample_ENABLE  output  1  one-cycle pulse at BAUD*OVERSAMPLE rate
- tx_ENABLE  output  1  one-cycle pulse at BAUD rate
- mid_ENABLE  output  1  one-cycle pulse at centre of each bit period

## Operation
- Reset: div counter, sample index samp_cnt, accumulator and the registered baud_select copy all clear to 0. All three outputs are 0.
- Divisor table, integer mode: DIV[sel] = round(CLK_FREQ / (BAUD[sel]*OVERSAMPLE)). It is computed at elaboration. With the defaults, 111 gives 27 and 000 gives 10417.
- Integer mode: div counter counts 0..DIV-1. On reaching DIV-1 it wraps to 0 and a sample tick is generated.
- Sample index: samp_cnt increments modulo OVERSAMPLE on every sample tick.
  - tx_ENABLE is asserted with the tick where samp_cnt = OVERSAMPLE-1.
  - mid_ENABLE is asserted with the tick where samp_cnt = OVERSAMPLE/2-1.
  - Both compare against the value before the increment.
- Rate change: baud_select is registered every cycle. If it differs from the registered copy, the div counter, samp_cnt and accumulator clear that cycle and no pulse is issued. Counting at the new rate starts from 0.
- sync: clears the div counter, samp_cnt and accumulator, and suppresses any tick that cycle. The next mid_ENABLE follows OVERSAMPLE/2 sample periods after sync.
- sync has priority over a tick that would occur in the same cycle. sync together with a rate change gives a single clear.
- en=0: all counters hold and all outputs are 0. sync and rate change still clear state.
- Reset asserted mid-period: immediate clear. Counting restarts from 0 after release.

## Timing
- All outputs are registered, each pulse exactly 1 clk wide. sample_ENABLE, tx_ENABLE and mid_ENABLE pulses coincide in the same cycle when applicable.
- Integer mode:
  - The first sample_ENABLE is high in the DIV-th cycle with en=1 after reset release.
  - Sample period is exactly DIV cycles.
  - tx_ENABLE period is exactly DIV*OVERSAMPLE cycles.
- Latency from a sync or baud_select change: the first sample_ENABLE follows DIV cycles after the clearing edge.
- tx_ENABLE and mid_ENABLE are never asserted without sample_ENABLE.

## Configuration
- BAUD_FRAC_EN defined: the divide counter is replaced by a phase accumulator.
  - Each enabled cycle: inc = BAUD[sel]*OVERSAMPLE.
  - If acc+inc >= CLK_FREQ: acc <= acc+inc-CLK_FREQ and a sample tick is issued. Otherwise acc <= acc+inc.
  - Tick spacing is floor or ceil of CLK_FREQ/inc, with zero long-term rate error.
  - The first tick occurs on the cycle where the accumulated sum first reaches CLK_FREQ.
- BAUD_FRAC_EN undefined: integer divider only, with rate error from rounding DIV. The accumulator logic is absent.
- samp_cnt, tx/mid strobes, sync, en and rate-change behaviour are identical in both builds.

## Test plan
- Reset held 150 ns, then released with en=1, sel=111, integer build -> outputs 0 during reset. sample_ENABLE pulses every 27 clk, the first on the 27th cycle after release. tx_ENABLE every 432 clk. mid_ENABLE 216 clk before each tx_ENABLE.
- Integer build, sel=111, 15625 cycles from release -> exactly 578 sample_ENABLE pulses. BAUD_FRAC_EN build, same stimulus -> exactly 576 pulses, all gaps 27 or 28 clk.
- sel changed 111->011 mid-period -> no pulse in the change cycle. The next sample_ENABLE arrives 326 clk later with period 326 thereafter.
- sync pulsed 10 clk after a sample tick, sel=111 -> no tick that cycle. sample_ENABLE 27 clk after sync. mid_ENABLE on the 8th tick, 216 clk after sync.
- en dropped for 50 cycles at div count 13, sel=111 -> no pulses while low. The next sample_ENABLE 14 clk after en returns.
- Reset asserted mid-bit with samp_cnt=9 -> all outputs 0 immediately. After release the first tx_ENABLE comes 432 clk later.
